// File: rtl/coffee_machine_pkg.sv
`default_nettype none
// ============================================================================
// Module : coffee_machine_pkg
// Brief  : Shared constants for the coffee-machine control stage: machine
//          state encodings, drink count, money/progress limits and a counter
//          width helper.
// Rev    : 1.0  initial release
// ============================================================================
package coffee_machine_pkg;

  // Machine state encodings (3-bit; 5..7 are illegal and recover to Waiting)
  localparam logic [2:0] ST_WAITING        = 3'd0;
  localparam logic [2:0] ST_SELECTION      = 3'd1;
  localparam logic [2:0] ST_PAYMENT        = 3'd2;
  localparam logic [2:0] ST_IMPLEMENTATION = 3'd3;
  localparam logic [2:0] ST_UNSUCCESSFUL   = 3'd4;

  localparam int         DRINK_COUNT = 4;
  localparam logic [7:0] MONEY_MAX   = 8'd99;
  localparam logic [7:0] PROCENT_MAX = 8'd100;

  // Width of a counter that runs 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module : button_conditioner
// Brief  : Conditions one raw active-low board button: 2-FF synchronizer,
//          debouncer that accepts a new level after DEBOUNCE_TICKS stable
//          clocks, and a one-clock press pulse on the accepted falling edge.
// Ports  : clk, rst_n (async active-low), button_n (raw, active-low),
//          press (1-clk pulse per accepted press)
// Rev    : 1.0  initial release
// ============================================================================
module button_conditioner
  import coffee_machine_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_n,
  output logic press
);

  localparam int                CNT_W    = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_d;
  logic             r_press;

  // Synchronizer and level registers reset to the released (high) level so
  // that leaving reset never produces a spurious press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_cnt     <= '0;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_press   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], button_n};
      r_level_d <= r_level;
      r_press   <= r_level_d & ~r_level;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/coffee_machine_ctrl.sv
`default_nettype none
// ============================================================================
// Module : coffee_machine_ctrl
// Brief  : Upstream control stage of the coffee machine. Conditions the four
//          raw buttons and runs the Waiting / Selection / Payment /
//          Implementation / Unsuccessful state machine.
// Ports  : clk, rst_n (async active-low); buttonWaiting, buttonLeft,
//          buttonRight, buttonSelection (raw, active-low);
//          state[2:0], selectionDrink[1:0], money[7:0], procent[7:0], brewDone
// Config : define COFFEE_PAY_TIMEOUT_EN to abort Payment after
//          PAY_TIMEOUT_TICKS clocks without an accepted press.
// Rev    : 1.0  initial release
// ============================================================================
module coffee_machine_ctrl
  import coffee_machine_pkg::*;
#(
  parameter int DEBOUNCE_TICKS    = 500000,
  parameter int PRICE0            = 15,
  parameter int PRICE1            = 20,
  parameter int PRICE2            = 25,
  parameter int PRICE3            = 30,
  parameter int COIN_VALUE        = 5,
  parameter int PROGRESS_TICKS    = 500000,
  parameter int DONE_TICKS        = 50000000,
  parameter int FAIL_TICKS        = 100000000,
  parameter int PAY_TIMEOUT_TICKS = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       buttonWaiting,
  input  logic       buttonLeft,
  input  logic       buttonRight,
  input  logic       buttonSelection,
  output logic [2:0] state,
  output logic [1:0] selectionDrink,
  output logic [7:0] money,
  output logic [7:0] procent,
  output logic       brewDone
);

  localparam int DRINK_W = $clog2(DRINK_COUNT);
  localparam int PROG_W  = cnt_width(PROGRESS_TICKS);
  localparam int DONE_W  = cnt_width(DONE_TICKS);
  localparam int FAIL_W  = cnt_width(FAIL_TICKS);
  localparam logic [PROG_W-1:0] PROG_LAST = PROG_W'(PROGRESS_TICKS - 1);
  localparam logic [DONE_W-1:0] DONE_LAST = DONE_W'(DONE_TICKS - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(FAIL_TICKS - 1);

  // --------------------------------------------------------------------------
  // Button conditioning: index 0 Waiting, 1 Selection, 2 Left, 3 Right
  // --------------------------------------------------------------------------
  logic [3:0] w_raw;
  logic [3:0] w_pulse;

  assign w_raw = {buttonRight, buttonLeft, buttonSelection, buttonWaiting};

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_btn (
      .clk      (clk),
      .rst_n    (rst_n),
      .button_n (w_raw[gi]),
      .press    (w_pulse[gi])
    );
  end

  // Only the highest-priority pulse of a cycle is acted on
  logic w_go_wait, w_go_sel, w_go_left, w_go_right;
  assign w_go_wait  = w_pulse[0];
  assign w_go_sel   = w_pulse[1] & ~w_pulse[0];
  assign w_go_left  = w_pulse[2] & ~w_pulse[1] & ~w_pulse[0];
  assign w_go_right = w_pulse[3] & ~w_pulse[2] & ~w_pulse[1] & ~w_pulse[0];

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [2:0]         r_state, r_state_next;
  logic [DRINK_W-1:0] r_drink;
  logic [7:0]         r_money, r_procent;
  logic               r_brew_done;
  logic [PROG_W-1:0]  r_prog_cnt;
  logic [DONE_W-1:0]  r_done_cnt;
  logic [FAIL_W-1:0]  r_fail_cnt;

  logic [31:0] w_price;
  logic        w_money_ok;
  logic [8:0]  w_money_sum;
  logic [7:0]  w_money_inc;
  logic        w_pay_timeout;

  always_comb begin
    w_price = 32'(PRICE0);
    case (r_drink)
      2'd0:    w_price = 32'(PRICE0);
      2'd1:    w_price = 32'(PRICE1);
      2'd2:    w_price = 32'(PRICE2);
      default: w_price = 32'(PRICE3);
    endcase
  end

  assign w_money_ok  = {24'd0, r_money} >= w_price;
  assign w_money_sum = {1'b0, r_money} + 9'(COIN_VALUE);
  assign w_money_inc = (w_money_sum > {1'b0, MONEY_MAX}) ? MONEY_MAX : w_money_sum[7:0];

`ifdef COFFEE_PAY_TIMEOUT_EN
  localparam int IDLE_W = cnt_width(PAY_TIMEOUT_TICKS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(PAY_TIMEOUT_TICKS - 1);
  logic [IDLE_W-1:0] r_idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if (r_state != ST_PAYMENT || r_state_next != r_state || (|w_pulse)) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign w_pay_timeout = (r_idle_cnt == IDLE_LAST);
`else
  // Timeout disabled: constant false for any legal (non-negative) setting
  assign w_pay_timeout = (PAY_TIMEOUT_TICKS < 0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAITING;
    end else begin
      r_state <= r_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    r_state_next = r_state;
    case (r_state)
      ST_WAITING: begin
        if (w_go_wait) r_state_next = ST_SELECTION;
      end
      ST_SELECTION: begin
        if (w_go_wait)     r_state_next = ST_WAITING;
        else if (w_go_sel) r_state_next = ST_PAYMENT;
      end
      ST_PAYMENT: begin
        if (w_money_ok)                    r_state_next = ST_IMPLEMENTATION;
        else if (w_go_wait || w_go_left)   r_state_next = ST_UNSUCCESSFUL;
        else if (w_pay_timeout)            r_state_next = ST_UNSUCCESSFUL;
      end
      ST_IMPLEMENTATION: begin
        if (r_procent == PROCENT_MAX && r_done_cnt == DONE_LAST) r_state_next = ST_WAITING;
      end
      ST_UNSUCCESSFUL: begin
        if (r_fail_cnt == FAIL_LAST) r_state_next = ST_WAITING;
      end
      default: r_state_next = ST_WAITING;
    endcase
  end

  // Datapath: drink, money, progress and tick counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drink     <= '0;
      r_money     <= '0;
      r_procent   <= '0;
      r_brew_done <= 1'b0;
      r_prog_cnt  <= '0;
      r_done_cnt  <= '0;
      r_fail_cnt  <= '0;
    end else begin
      r_brew_done <= 1'b0;
      case (r_state)
        ST_WAITING: begin
          if (w_go_wait) begin
            r_drink   <= '0;
            r_money   <= '0;
            r_procent <= '0;
          end
        end
        ST_SELECTION: begin
          if (w_go_left)       r_drink <= r_drink - 1'b1;
          else if (w_go_right) r_drink <= r_drink + 1'b1;
        end
        ST_PAYMENT: begin
          if (r_state_next == ST_PAYMENT && w_go_right) r_money <= w_money_inc;
        end
        ST_IMPLEMENTATION: begin
          if (r_state_next == ST_WAITING) begin
            r_money   <= '0;
            r_procent <= '0;
          end else if (r_procent < PROCENT_MAX) begin
            if (r_prog_cnt == PROG_LAST) begin
              r_prog_cnt <= '0;
              r_procent  <= r_procent + 8'd1;
              if (r_procent == PROCENT_MAX - 8'd1) r_brew_done <= 1'b1;
            end else begin
              r_prog_cnt <= r_prog_cnt + 1'b1;
            end
          end else begin
            r_done_cnt <= r_done_cnt + 1'b1;
          end
        end
        ST_UNSUCCESSFUL: begin
          if (r_state_next == ST_WAITING) r_money    <= '0;
          else                            r_fail_cnt <= r_fail_cnt + 1'b1;
        end
        default: ;
      endcase
      // Every state change restarts all tick counters (overrides the above)
      if (r_state_next != r_state) begin
        r_prog_cnt <= '0;
        r_done_cnt <= '0;
        r_fail_cnt <= '0;
      end
    end
  end

  // Output logic
  always_comb begin
    state          = r_state;
    selectionDrink = r_drink;
    money          = r_money;
    procent        = r_procent;
    brewDone       = r_brew_done;
  end

endmodule
`default_nettype wire

// File: tb/tb_coffee_machine_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_coffee_machine_ctrl
// Brief  : Directed self-checking bench for coffee_machine_ctrl with short
//          timing parameters. PRICE0 is raised to 200 so drink 0 can never be
//          paid, which exercises money saturation and cancel.
// Rev    : 1.0  initial release
// ============================================================================
module tb_coffee_machine_ctrl;

  localparam int DEB = 4;
  localparam int HOLD = DEB + 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       b_wait = 1'b1, b_left = 1'b1, b_right = 1'b1, b_sel = 1'b1;
  logic [2:0] state;
  logic [1:0] drink;
  logic [7:0] money, procent;
  logic       brew_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  coffee_machine_ctrl #(
    .DEBOUNCE_TICKS    (DEB),
    .PRICE0            (200),
    .PRICE1            (20),
    .PRICE2            (25),
    .PRICE3            (30),
    .COIN_VALUE        (5),
    .PROGRESS_TICKS    (2),
    .DONE_TICKS        (10),
    .FAIL_TICKS        (10),
    .PAY_TIMEOUT_TICKS (50)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .buttonWaiting   (b_wait),
    .buttonLeft      (b_left),
    .buttonRight     (b_right),
    .buttonSelection (b_sel),
    .state           (state),
    .selectionDrink  (drink),
    .money           (money),
    .procent         (procent),
    .brewDone        (brew_done)
  );

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 0 Waiting, 1 Selection, 2 Left, 3 Right
  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: b_wait  = v;
      1: b_sel   = v;
      2: b_left  = v;
      default: b_right = v;
    endcase
  endtask

  task automatic press(input int idx);
    @(negedge clk);
    set_btn(idx, 1'b0);
    cycles(HOLD);
    set_btn(idx, 1'b1);
    cycles(HOLD);
  endtask

  initial begin
    // ---------------- reset / wake ----------------
    cycles(3);
    check("rst_state", state, 0);
    check("rst_money", money, 0);
    rst_n = 1'b1;
    cycles(3);
    check("idle_state", state, 0);
    check("idle_drink", drink, 0);
    check("idle_money", money, 0);
    check("idle_procent", procent, 0);
    check("idle_brewdone", brew_done, 0);
    press(0);
    check("wake_state", state, 1);
    check("wake_drink", drink, 0);

    // ---------------- drink wrap ----------------
    press(2);
    check("left_wrap", drink, 3);
    press(3);
    check("right_wrap", drink, 0);
    press(3);
    check("right_inc", drink, 1);
    @(negedge clk);
    b_right = 1'b0;
    cycles(3);
    b_right = 1'b1;
    cycles(HOLD);
    check("glitch_ignored", drink, 1);

    // ---------------- simultaneous Left+Right ----------------
    @(negedge clk);
    b_left = 1'b0; b_right = 1'b0;
    cycles(HOLD);
    b_left = 1'b1; b_right = 1'b1;
    cycles(HOLD);
    check("left_wins", drink, 0);

    // ---------------- pay / brew drink 2 ----------------
    press(3);
    press(3);
    check("drink2", drink, 2);
    press(1);
    check("pay_state", state, 2);
    press(3);
    check("coin1", money, 5);
    for (int i = 0; i < 4; i++) press(3);
    check("paid_money", money, 25);
    check("brew_state", state, 3);
    begin
      int last, run, bad, pulses, at100;
      bit first;
      last = procent; run = 0; bad = 0; pulses = 0; at100 = 0; first = 1'b1;
      for (int i = 0; i < 600; i++) begin
        @(negedge clk);
        if (state != 3) break;
        if (brew_done) pulses++;
        if (procent > 100) bad++;
        if (procent == 100) at100++;
        if (procent != last) begin
          if (procent != last + 1) bad++;
          if (!first && run != 2) bad++;
          first = 1'b0;
          run = 1;
          last = procent;
        end else begin
          run++;
        end
      end
      check("brew_steps_bad", bad, 0);
      check("brew_done_pulses", pulses, 1);
      check("cycles_at_100", at100, 10);
    end
    check("after_brew_state", state, 0);
    check("after_brew_money", money, 0);
    check("after_brew_procent", procent, 0);

    // ---------------- saturation / cancel (drink 0 costs 200) ----------------
    press(0);
    press(1);
    check("sat_pay_state", state, 2);
    for (int i = 0; i < 25; i++) press(3);
    check("sat_money", money, 99);
    check("sat_state", state, 2);
    @(negedge clk);
    b_left = 1'b0;
    begin
      int k;
      for (k = 0; k < 40 && state != 4; k++) @(negedge clk);
      check("cancel_state", state, 4);
    end
    b_left = 1'b1;
    check("refund_money", money, 99);
    cycles(5);
    check("unsucc_hold", state, 4);
    cycles(7);
    check("unsucc_exit_state", state, 0);
    check("unsucc_exit_money", money, 0);

    // ---------------- payment timeout ----------------
    press(0);
    press(1);
    check("to_pay_state", state, 2);
    cycles(60);
`ifdef COFFEE_PAY_TIMEOUT_EN
    check("timeout_state", state, 4);
`else
    check("no_timeout_state", state, 2);
`endif
    rst_n = 1'b0;
    cycles(2);
    check("rst_pay_state", state, 0);
    rst_n = 1'b1;
    cycles(2);

    // ---------------- reset mid-brew ----------------
    press(0);
    press(3);
    press(3);
    press(1);
    for (int i = 0; i < 5; i++) press(3);
    begin
      int k;
      for (k = 0; k < 300 && procent != 40; k++) @(negedge clk);
      check("reach_40", procent, 40);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midbrew_state", state, 0);
    check("midbrew_procent", procent, 0);
    check("midbrew_money", money, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    check("no_resume_state", state, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
